adc_capture_mem_ctrl: RTL and testbench

- Sequencer for the single-port 32768x36 capture SRAM (active-low CEB/WEB, 1-cycle read latency) in the ADC capture path.
- Writes the ADC sample stream into the SRAM as a circular pre-trigger buffer, then stores a programmable number of post-trigger samples and freezes.
- Reads the frozen buffer out, oldest sample first, over a valid/ready stream to the packet controller.
- The SRAM port is never shared between capture writes and read-out in the same state.

---
 rtl/adc_capture_mem_ctrl_if.sv | 46 ++++
 rtl/adc_capture_mem_ctrl.sv | 235 +++++++++++++++++++++++
 tb/tb_adc_capture_mem_ctrl.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/adc_capture_mem_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : adc_capture_mem_ctrl_if
// Brief    : Control, sample-in, read-out and SRAM bundle of the ADC capture
//            memory sequencer.
// Revision : 1.0  initial release
// ============================================================================
interface adc_capture_mem_ctrl_if #(
  parameter int ADDR_WIDTH = 15,
  parameter int DATA_WIDTH = 36
);
  logic                  start;
  logic                  trig;
  logic [ADDR_WIDTH-1:0] cfg_post_cnt;
  logic                  wr_vld;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  rd_go;
  logic                  rd_vld;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_last;
  logic                  rd_ready;
  logic                  busy;
  logic                  done;
  logic                  wrapped;
  logic [ADDR_WIDTH-1:0] trig_addr;
  logic                  mem_ceb;
  logic                  mem_web;
  logic [ADDR_WIDTH-1:0] mem_a;
  logic [DATA_WIDTH-1:0] mem_d;
  logic [DATA_WIDTH-1:0] mem_q;

  // Environment side: drives commands, samples, downstream ready and SRAM data.
  modport master (
    output start, trig, cfg_post_cnt, wr_vld, wr_data, rd_go, rd_ready, mem_q,
    input  rd_vld, rd_data, rd_last, busy, done, wrapped, trig_addr,
           mem_ceb, mem_web, mem_a, mem_d
  );

  // Sequencer side.
  modport slave (
    input  start, trig, cfg_post_cnt, wr_vld, wr_data, rd_go, rd_ready, mem_q,
    output rd_vld, rd_data, rd_last, busy, done, wrapped, trig_addr,
           mem_ceb, mem_web, mem_a, mem_d
  );
endinterface
`default_nettype wire

// File: rtl/adc_capture_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : adc_capture_mem_ctrl
// Brief    : Circular pre/post-trigger capture into a single-port SRAM and
//            oldest-first read-out over a valid/ready stream.
// Revision : 1.0  initial release
// ============================================================================
module adc_capture_mem_ctrl #(
  parameter int ADDR_WIDTH = 15,
  parameter int DATA_WIDTH = 36
) (
  input  logic                 CLK,
  input  logic                 RST,
  adc_capture_mem_ctrl_if.slave bus
);

  // Read-out buffer must cover command register + SRAM latency + one word
  // being consumed to sustain one word per cycle.
  localparam int FIFO_DEPTH = 4;
  localparam logic [ADDR_WIDTH:0] DEPTH_CNT = {1'b1, {ADDR_WIDTH{1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ARMED = 3'd1,
    S_POST  = 3'd2,
    S_DONE  = 3'd3,
    S_READ  = 3'd4
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic                  wrapped_q, wrapped_d;
  logic [ADDR_WIDTH-1:0] trig_addr_q, trig_addr_d;
  logic [ADDR_WIDTH-1:0] post_rem_q, post_rem_d;
  logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
  logic [ADDR_WIDTH:0]   rd_rem_q, rd_rem_d;
  logic                  mem_ceb_q, mem_ceb_d, mem_web_q, mem_web_d;
  logic [ADDR_WIDTH-1:0] mem_a_q, mem_a_d;
  logic [DATA_WIDTH-1:0] mem_d_q, mem_d_d;
  logic                  busy_q, busy_d, done_q, done_d;
  // p1: read command on the SRAM pins; p2: its data on mem_q.
  logic                  rd_p1_q, rd_p1_d, rd_p1_last_q, rd_p1_last_d;
  logic                  rd_p2_q, rd_p2_d, rd_p2_last_q, rd_p2_last_d;
  logic [DATA_WIDTH-1:0] fifo_data_q [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] fifo_data_d [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] fifo_last_q, fifo_last_d;
  logic [1:0]            fifo_rd_q, fifo_rd_d, fifo_wr_q, fifo_wr_d;
  logic [2:0]            fifo_cnt_q, fifo_cnt_d;

  logic                  w_rd_vld;
  logic                  w_pop;
  logic [2:0]            w_credits;
  logic                  rd_req;

  assign w_rd_vld  = (fifo_cnt_q != 3'd0);
  assign w_pop     = w_rd_vld & bus.rd_ready;
  // Words the buffer is committed to hold once the current pop completes.
  assign w_credits = fifo_cnt_q - {2'b00, w_pop} + {2'b00, rd_p1_q} + {2'b00, rd_p2_q};

  assign bus.rd_vld    = w_rd_vld;
  assign bus.rd_data   = fifo_data_q[fifo_rd_q];
  assign bus.rd_last   = w_rd_vld & fifo_last_q[fifo_rd_q];
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.wrapped   = wrapped_q;
  assign bus.trig_addr = trig_addr_q;
  assign bus.mem_ceb   = mem_ceb_q;
  assign bus.mem_web   = mem_web_q;
  assign bus.mem_a     = mem_a_q;
  assign bus.mem_d     = mem_d_q;

  // Next-state, SRAM command and read-out buffer bookkeeping.
  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    wrapped_d    = wrapped_q;
    trig_addr_d  = trig_addr_q;
    post_rem_d   = post_rem_q;
    rd_addr_d    = rd_addr_q;
    rd_rem_d     = rd_rem_q;
    mem_ceb_d    = 1'b1;
    mem_web_d    = 1'b1;
    mem_a_d      = mem_a_q;
    mem_d_d      = mem_d_q;
    rd_p1_d      = 1'b0;
    rd_p1_last_d = 1'b0;
    rd_p2_d      = rd_p1_q;
    rd_p2_last_d = rd_p1_last_q;
    fifo_data_d  = fifo_data_q;
    fifo_last_d  = fifo_last_q;
    fifo_rd_d    = fifo_rd_q;
    fifo_wr_d    = fifo_wr_q;
    rd_req       = 1'b0;

    if (rd_p2_q) begin
      fifo_data_d[fifo_wr_q] = bus.mem_q;
      fifo_last_d[fifo_wr_q] = rd_p2_last_q;
      fifo_wr_d              = fifo_wr_q + 2'd1;
    end
    if (w_pop) begin
      fifo_rd_d = fifo_rd_q + 2'd1;
    end
    fifo_cnt_d = fifo_cnt_q + {2'b00, rd_p2_q} - {2'b00, w_pop};

    case (state_q)
      S_IDLE: ;
      S_ARMED, S_POST: begin
        if (bus.wr_vld) begin
          mem_ceb_d = 1'b0;
          mem_web_d = 1'b0;
          mem_a_d   = wr_ptr_q;
          mem_d_d   = bus.wr_data;
          wr_ptr_d  = wr_ptr_q + ADDR_WIDTH'(1);
          if (wr_ptr_q == '1) begin
            wrapped_d = 1'b1;
          end
          if (state_q == S_POST) begin
            post_rem_d = post_rem_q - ADDR_WIDTH'(1);
            if (post_rem_q == ADDR_WIDTH'(1)) begin
              state_d = S_DONE;
            end
          end
        end
        // A same-cycle sample is pre-trigger, so the trigger lands after it.
        if (state_q == S_ARMED && bus.trig) begin
          trig_addr_d = wr_ptr_d;
          post_rem_d  = bus.cfg_post_cnt;
          state_d     = (bus.cfg_post_cnt == '0) ? S_DONE : S_POST;
        end
      end
      S_DONE: begin
        if (bus.rd_go) begin
          rd_addr_d = wrapped_q ? wr_ptr_q : '0;
          rd_rem_d  = wrapped_q ? DEPTH_CNT : {1'b0, wr_ptr_q};
          state_d   = (rd_rem_d == '0) ? S_IDLE : S_READ;
          // First read issues here to shave a cycle off read-out latency.
          rd_req    = (rd_rem_d != '0);
        end
      end
      S_READ: begin
        rd_req = (rd_rem_q != '0) && (w_credits < 3'(FIFO_DEPTH));
        if (w_pop && fifo_last_q[fifo_rd_q]) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (rd_req) begin
      mem_ceb_d    = 1'b0;
      mem_web_d    = 1'b1;
      mem_a_d      = rd_addr_d;
      rd_addr_d    = rd_addr_d + ADDR_WIDTH'(1);
      rd_p1_d      = 1'b1;
      rd_p1_last_d = (rd_rem_d == (ADDR_WIDTH+1)'(1));
      rd_rem_d     = rd_rem_d - (ADDR_WIDTH+1)'(1);
    end

    // start overrides everything, including a same-cycle trigger or sample.
    if (bus.start) begin
      state_d      = S_ARMED;
      wr_ptr_d     = '0;
      wrapped_d    = 1'b0;
      trig_addr_d  = '0;
      rd_rem_d     = '0;
      mem_ceb_d    = 1'b1;
      mem_web_d    = 1'b1;
      mem_a_d      = mem_a_q;
      mem_d_d      = mem_d_q;
      rd_p1_d      = 1'b0;
      rd_p1_last_d = 1'b0;
      rd_p2_d      = 1'b0;
      rd_p2_last_d = 1'b0;
      fifo_rd_d    = 2'd0;
      fifo_wr_d    = 2'd0;
      fifo_cnt_d   = 3'd0;
    end

    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  // State, pointer, SRAM-command and buffer registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= S_IDLE;
      wr_ptr_q     <= '0;
      wrapped_q    <= 1'b0;
      trig_addr_q  <= '0;
      post_rem_q   <= '0;
      rd_addr_q    <= '0;
      rd_rem_q     <= '0;
      mem_ceb_q    <= 1'b1;
      mem_web_q    <= 1'b1;
      mem_a_q      <= '0;
      mem_d_q      <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      rd_p1_q      <= 1'b0;
      rd_p1_last_q <= 1'b0;
      rd_p2_q      <= 1'b0;
      rd_p2_last_q <= 1'b0;
      fifo_data_q  <= '{default: '0};
      fifo_last_q  <= '0;
      fifo_rd_q    <= 2'd0;
      fifo_wr_q    <= 2'd0;
      fifo_cnt_q   <= 3'd0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      wrapped_q    <= wrapped_d;
      trig_addr_q  <= trig_addr_d;
      post_rem_q   <= post_rem_d;
      rd_addr_q    <= rd_addr_d;
      rd_rem_q     <= rd_rem_d;
      mem_ceb_q    <= mem_ceb_d;
      mem_web_q    <= mem_web_d;
      mem_a_q      <= mem_a_d;
      mem_d_q      <= mem_d_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      rd_p1_q      <= rd_p1_d;
      rd_p1_last_q <= rd_p1_last_d;
      rd_p2_q      <= rd_p2_d;
      rd_p2_last_q <= rd_p2_last_d;
      fifo_data_q  <= fifo_data_d;
      fifo_last_q  <= fifo_last_d;
      fifo_rd_q    <= fifo_rd_d;
      fifo_wr_q    <= fifo_wr_d;
      fifo_cnt_q   <= fifo_cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_adc_capture_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_adc_capture_mem_ctrl
// Brief    : Self-checking bench for adc_capture_mem_ctrl (DEPTH 16) with an
//            SRAM model and a sample-history reference model.
// Revision : 1.0  initial release
// ============================================================================
module tb_adc_capture_mem_ctrl;
  localparam int AW    = 4;
  localparam int DW    = 36;
  localparam int DEPTH = 16;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;
  int   n_writes = 0;
  int   wr_base  = 0;
  logic [DW-1:0] sram [DEPTH];
  logic [DW-1:0] cap_q [$];
  bit            pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

  always #5 CLK = ~CLK;

  adc_capture_mem_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  adc_capture_mem_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  // Single-port SRAM, 1-cycle read latency, active-low controls.
  always @(posedge CLK) begin
    if (!bus.mem_ceb) begin
      if (!bus.mem_web) begin
        sram[bus.mem_a] <= bus.mem_d;
        n_writes        <= n_writes + 1;
      end else begin
        bus.mem_q <= sram[bus.mem_a];
      end
    end
  end

  task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_value({tag, "_rd_vld"},    bus.rd_vld, 0);
    check_value({tag, "_rd_last"},   bus.rd_last, 0);
    check_value({tag, "_rd_data"},   bus.rd_data, 0);
    check_value({tag, "_busy"},      bus.busy, 0);
    check_value({tag, "_done"},      bus.done, 0);
    check_value({tag, "_wrapped"},   bus.wrapped, 0);
    check_value({tag, "_trig_addr"}, bus.trig_addr, 0);
    check_value({tag, "_mem_ceb"},   bus.mem_ceb, 1);
    check_value({tag, "_mem_web"},   bus.mem_web, 1);
    check_value({tag, "_mem_a"},     bus.mem_a, 0);
    check_value({tag, "_mem_d"},     bus.mem_d, 0);
  endtask

  task automatic do_start();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    cap_q.delete();
    wr_base = n_writes;
    check_value("start_busy", bus.busy, 1);
  endtask

  task automatic push_sample(input logic [DW-1:0] d);
    bus.wr_vld  = 1'b1;
    bus.wr_data = d;
    tick();
    bus.wr_vld  = 1'b0;
    cap_q.push_back(d);
  endtask

  // Capture npre samples, trigger (optionally with a sample), then npost samples.
  task automatic capture(input int npre, input int npost, input bit vld_on_trig,
                         input int gap_max, input logic [DW-1:0] base);
    int k = 0;
    for (int i = 0; i < npre; i++) begin
      push_sample(base + DW'(k));
      k++;
      repeat ($urandom_range(0, gap_max)) tick();
    end
    bus.trig         = 1'b1;
    bus.cfg_post_cnt = AW'(npost);
    if (vld_on_trig) begin
      bus.wr_vld  = 1'b1;
      bus.wr_data = base + DW'(k);
      cap_q.push_back(base + DW'(k));
      k++;
    end
    tick();
    bus.trig         = 1'b0;
    bus.wr_vld       = 1'b0;
    bus.cfg_post_cnt = AW'($urandom);
    check_value("trig_addr", bus.trig_addr, cap_q.size() % DEPTH);
    if (npost == 0) begin
      check_value("zero_post_done", bus.done, 1);
    end else begin
      check_value("post_done_early", bus.done, 0);
      for (int i = 0; i < npost; i++) begin
        repeat ($urandom_range(0, gap_max)) tick();
        push_sample(base + DW'(k));
        k++;
      end
    end
    check_value("cap_done", bus.done, 1);
    check_value("cap_wrapped", bus.wrapped, cap_q.size() >= DEPTH);
    // Samples offered in DONE must not reach the SRAM.
    bus.wr_vld  = 1'b1;
    bus.wr_data = '1;
    repeat (2) tick();
    bus.wr_vld  = 1'b0;
    tick();
    check_value("cap_writes", n_writes - wr_base, cap_q.size());
    check_value("done_hold", bus.done, 1);
  endtask

  // ready_mode: 0 always ready, 1 fixed pattern, 2 random.
  task automatic readout(input int ready_mode, input int abort_at, input int rst_at, input bit chk_timing);
    logic [DW-1:0] exp_q [$];
    logic [DW-1:0] prev_data = '0;
    bit            prev_stall = 1'b0;
    bit            r;
    int            got = 0;
    int            edge_n;
    int            first = -1;
    int            last_xfer = -1;
    int            n = cap_q.size();
    for (int i = (n > DEPTH) ? n - DEPTH : 0; i < n; i++) exp_q.push_back(cap_q[i]);
    bus.rd_go = 1'b1;
    tick();
    bus.rd_go = 1'b0;
    edge_n = 1;
    while (edge_n < 400) begin
      if (!bus.busy) break;
      if (abort_at >= 0 && got == abort_at && bus.rd_vld) begin
        bus.rd_ready = 1'b0;
        bus.start    = 1'b1;
        tick();
        bus.start    = 1'b0;
        check_value("abort_rd_vld", bus.rd_vld, 0);
        check_value("abort_busy", bus.busy, 1);
        check_value("abort_wrapped", bus.wrapped, 0);
        check_value("abort_done", bus.done, 0);
        check_value("abort_trig_addr", bus.trig_addr, 0);
        cap_q.delete();
        wr_base = n_writes;
        return;
      end
      if (rst_at >= 0 && got == rst_at) begin
        bus.rd_ready = 1'b0;
        RST = 1'b1;
        tick();
        RST = 1'b0;
        check_reset_outputs("mid_read_rst");
        return;
      end
      case (ready_mode)
        0:       r = 1'b1;
        1:       r = pat[edge_n % 6];
        default: r = 1'($urandom_range(0, 1));
      endcase
      bus.rd_ready = r;
      if (prev_stall) begin
        check_value("hold_vld", bus.rd_vld, 1);
        check_value("hold_data", bus.rd_data, prev_data);
      end
      if (bus.rd_vld && first < 0) first = edge_n;
      if (bus.rd_vld && r) begin
        if (got < exp_q.size()) begin
          check_value("rd_data", bus.rd_data, exp_q[got]);
          check_value("rd_last", bus.rd_last, got == exp_q.size() - 1);
        end else begin
          check_value("rd_extra", got + 1, exp_q.size());
        end
        got++;
        last_xfer = edge_n;
      end
      prev_stall = bus.rd_vld && !r;
      prev_data  = bus.rd_data;
      tick();
      edge_n++;
    end
    bus.rd_ready = 1'b0;
    check_value("rd_count", got, exp_q.size());
    check_value("rd_end_busy", bus.busy, 0);
    if (chk_timing && exp_q.size() > 0) begin
      check_value("rd_first_latency", first, 3);
      check_value("rd_back_to_back", last_xfer - first, exp_q.size() - 1);
    end
  endtask

  initial begin
    int snap;
    bus.start = 0; bus.trig = 0; bus.cfg_post_cnt = '0; bus.wr_vld = 0;
    bus.wr_data = '0; bus.rd_go = 0; bus.rd_ready = 0;
    RST = 1'b1;
    repeat (2) tick();
    RST = 1'b0;
    check_reset_outputs("reset");

    // Inputs other than start are ignored while idle.
    snap = n_writes;
    bus.trig = 1; bus.wr_vld = 1; bus.rd_go = 1; bus.wr_data = 36'h5;
    tick();
    bus.trig = 0; bus.wr_vld = 0; bus.rd_go = 0;
    check_value("idle_ceb", bus.mem_ceb, 1);
    check_value("idle_busy", bus.busy, 0);
    tick();
    check_value("idle_ceb2", bus.mem_ceb, 1);
    check_value("idle_writes", n_writes - snap, 0);

    // No wrap.
    do_start();
    capture(5, 3, 1'b0, 0, '0);
    readout(0, -1, -1, 1'b1);

    // Wrap.
    do_start();
    capture(20, 4, 1'b0, 0, '0);
    readout(0, -1, -1, 1'b1);

    // Backpressure pattern.
    do_start();
    capture(5, 3, 1'b0, 0, '0);
    readout(1, -1, -1, 1'b0);

    // Zero post-trigger count with a same-cycle sample (data 9 at address 3).
    do_start();
    capture(3, 0, 1'b1, 0, 36'd6);
    readout(0, -1, -1, 1'b1);

    // Abort while the fourth word is pending, then a fresh capture.
    do_start();
    capture(5, 3, 1'b0, 0, '0);
    readout(0, 3, -1, 1'b0);
    capture(5, 3, 1'b0, 0, '0);
    readout(0, -1, -1, 1'b1);

    // Reset in the middle of read-out.
    do_start();
    capture(10, 2, 1'b0, 1, 36'h100);
    readout(2, -1, 4, 1'b0);

    // Randomized captures and read-outs.
    for (int it = 0; it < 14; it++) begin
      int mode = $urandom_range(0, 2);
      do_start();
      capture($urandom_range(0, 40), $urandom_range(0, 15), 1'($urandom_range(0, 1)),
              2, DW'($urandom));
      readout(mode, -1, -1, mode == 0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
`default_nettype wire
